// File: rtl/iterative_shifter.sv
// iterative_shifter
// Multicycle 32-bit shift unit for the execute stage. Each clock applies one
// power-of-two stage (16, 8, 4, 2, 1), so every operation takes exactly
// SHAMT_W cycles from accept to result, whatever the shift amount.
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous active-low reset
//   ctrl_shift      start pulse, accepted in IDLE or DONE
//   data_operandA   value to shift, sampled on the accept edge
//   shamt           shift amount, sampled on the accept edge
//   shift_op        00 SLL, 01 SRA, 10 SRL, 11 ROL, sampled on the accept edge
//   data_result     shifted value, valid while data_resultRDY=1
//   data_resultRDY  result valid, held until the next accept or reset
//   busy            operation in progress
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing in flight, waiting for ctrl_shift
// SHIFT | applying stage idx (SHAMT_W-1 down to 0), ctrl_shift ignored
// DONE  | result held on data_result, a new ctrl_shift is accepted

module iterative_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_shift,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         shift_op,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);

    localparam int IDX_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] amt;
    logic [1:0]         op;
    logic [IDX_W-1:0]   idx;

    logic [SHAMT_W:0]   stage_dist;
    logic [SHAMT_W:0]   rot_back;
    logic [WIDTH-1:0]   stage_val;
    logic [WIDTH-1:0]   next_acc;

    // Distance for the current stage is 2**idx; the rotate recombines the
    // bits pushed out of the top, which needs the complementary distance.
    assign stage_dist = (SHAMT_W+1)'(1) << idx;
    assign rot_back   = (SHAMT_W+1)'(WIDTH) - stage_dist;

    always_comb begin
        stage_val = acc;
        case (op)
            OP_SLL: stage_val = acc << stage_dist;
            OP_SRA: stage_val = $unsigned($signed(acc) >>> stage_dist);
            OP_SRL: stage_val = acc >> stage_dist;
            OP_ROL: stage_val = (acc << stage_dist) | (acc >> rot_back);
            default: stage_val = acc;
        endcase
    end

    assign next_acc = amt[idx] ? stage_val : acc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            acc            <= '0;
            amt            <= '0;
            op             <= '0;
            idx            <= '0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy           <= 1'b0;
                    data_resultRDY <= 1'b0;
                    if (ctrl_shift) begin
                        acc   <= data_operandA;
                        amt   <= shamt;
                        op    <= shift_op;
                        idx   <= IDX_W'(SHAMT_W - 1);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= next_acc;
                    if (idx == '0) begin
                        data_result    <= next_acc;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (ctrl_shift) begin
                        acc            <= data_operandA;
                        amt            <= shamt;
                        op             <= shift_op;
                        idx            <= IDX_W'(SHAMT_W - 1);
                        busy           <= 1'b1;
                        data_resultRDY <= 1'b0;
                        state          <= SHIFT;
                    end
                end
                default: begin
                    busy           <= 1'b0;
                    data_resultRDY <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_shifter.sv
// Testbench for iterative_shifter: directed vectors with hand-computed
// results, a mid-operation reset, busy-time start pulses, back-to-back
// accepts and a random sweep against a full-width reference shift.

module tb_iterative_shifter;

    logic        clock;
    logic        reset;
    logic        ctrl_shift;
    logic [31:0] data_operandA;
    logic [4:0]  shamt;
    logic [1:0]  shift_op;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int total = 0;
    int bad   = 0;

    iterative_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_shift     (ctrl_shift),
        .data_operandA  (data_operandA),
        .shamt          (shamt),
        .shift_op       (shift_op),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: one full-width shift, independent of the staged datapath.
    function automatic logic [31:0] gold(input logic [31:0] a, input logic [4:0] s,
                                         input logic [1:0] o);
        logic [63:0] dbl;
        case (o)
            2'b00:   gold = a << s;
            2'b01:   gold = $unsigned($signed(a) >>> s);
            2'b10:   gold = a >> s;
            default: begin
                dbl  = {a, a} << s;
                gold = dbl[63:32];
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge; drives the start pulse, optionally pokes ctrl_shift
    // during SHIFT (poke_at = 1..4), checks busy/RDY every cycle and the result
    // after the 5th edge. Returns at the negedge of the first DONE cycle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] s,
                          input logic [1:0] o, input logic [31:0] exp, input int poke_at);
        ctrl_shift    = 1'b1;
        data_operandA = a;
        shamt         = s;
        shift_op      = o;
        @(posedge clock);
        @(negedge clock);
        ctrl_shift    = 1'b0;
        data_operandA = $urandom;
        shamt         = 5'($urandom);
        shift_op      = 2'($urandom);
        for (int k = 1; k <= 5; k++) begin
            chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
            chk({tag, "_rdy_low"}, {31'b0, data_resultRDY}, 32'd0);
            if (k == poke_at) begin
                ctrl_shift    = 1'b1;
                data_operandA = 32'h1;
                shamt         = 5'd1;
                shift_op      = 2'b00;
            end
            @(posedge clock);
            @(negedge clock);
            ctrl_shift = 1'b0;
        end
        chk({tag, "_rdy"}, {31'b0, data_resultRDY}, 32'd1);
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
        chk({tag, "_result"}, data_result, exp);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] ra;
        logic [4:0]  rs;
        logic [1:0]  ro;

        reset         = 1'b0;
        ctrl_shift    = 1'b1;
        data_operandA = 32'hFFFF_FFFF;
        shamt         = 5'd3;
        shift_op      = 2'b00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_result", data_result, 32'h0);
        chk("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        ctrl_shift = 1'b0;
        reset      = 1'b1;
        @(negedge clock);

        run_op("sra8",  32'h8000_0000, 5'd8,  2'b01, 32'hFF80_0000, 0);
        run_op("sll8",  32'h0000_00FF, 5'd8,  2'b00, 32'h0000_FF00, 0);
        run_op("srl31", 32'h8000_0000, 5'd31, 2'b10, 32'h0000_0001, 0);
        run_op("rol4",  32'h8000_0001, 5'd4,  2'b11, 32'h0000_0018, 0);
        run_op("sra31", 32'h8000_1234, 5'd31, 2'b01, 32'hFFFF_FFFF, 0);
        run_op("rol31", 32'h0000_0003, 5'd31, 2'b11, 32'h8000_0001, 0);
        run_op("sra0",  32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF, 0);

        held = data_result;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("hold_rdy", {31'b0, data_resultRDY}, 32'd1);
            chk("hold_result", data_result, held);
        end

        // start pulse during SHIFT is ignored; the next op is then accepted
        // in the first DONE cycle
        run_op("busy_ign", 32'h1234_5678, 5'd4, 2'b00, 32'h2345_6780, 2);
        run_op("b2b",      32'h0000_00F0, 5'd4, 2'b10, 32'h0000_000F, 0);

        // reset two cycles after accept aborts the op
        ctrl_shift    = 1'b1;
        data_operandA = 32'hFFFF_0000;
        shamt         = 5'd4;
        shift_op      = 2'b01;
        @(posedge clock);
        @(negedge clock);
        ctrl_shift = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_rdy", {31'b0, data_resultRDY}, 32'd0);
        chk("abort_result", data_result, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("abort_no_rdy", {31'b0, data_resultRDY}, 32'd0);
        end
        run_op("after_abort", 32'h0F00_0000, 5'd12, 2'b11, 32'h0000_00F0, 0);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rs = 5'($urandom_range(0, 31));
            ro = 2'($urandom_range(0, 3));
            run_op("rand", ra, rs, ro, gold(ra, rs, ro), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
- Multicycle 32-bit shift unit for the processor's execute stage.
- Performs logical-left, arithmetic-right, logical-right and rotate-left shifts.
- Applies one power-of-two stage (16, 8, 4, 2, 1) per clock, which removes the wide combinational barrel shifter from the ALU critical path.
- Uses the same start/ready handshake as the multdiv unit: the pipeline stalls on busy and latches data_result when data_resultRDY rises.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; WIDTH == 2**SHAMT_W.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset, sampled on rising edge of clock.
- ctrl_shift  input  1  start pulse; accepted when not busy.
- data_operandA  input  WIDTH  value to shift; sampled on the accept edge.
- shamt  input  SHAMT_W  shift amount; sampled on the accept edge.
- shift_op  input  2  operation: 00 SLL, 01 SRA, 10 SRL, 11 ROL; sampled on the accept edge.
- data_result  output  WIDTH  shifted value; valid while data_resultRDY=1.
- data_resultRDY  output  1  result valid; held until the next accept or reset.
- busy  output  1  operation in progress.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE.
  - data_result=0, data_resultRDY=0, busy=0.
  - Internal shift register, amount, op and stage index all cleared.
  - Reset overrides everything, including mid-operation and a simultaneous ctrl_shift; the in-flight op is discarded and no RDY is produced.
- State IDLE:
  - busy=0, data_resultRDY=0.
  - ctrl_shift=1 at an edge is the accept event: load acc=data_operandA, amt=shamt, op=shift_op, idx=SHAMT_W-1. Next state SHIFT.
- State SHIFT:
  - busy=1, data_resultRDY=0.
  - Each edge: if amt[idx]=1, acc is replaced by acc shifted by 2**idx per op; otherwise acc is unchanged. Then idx decrements.
  - Shift rules:
    - SLL fills zeros at the LSB.
    - SRA replicates acc[WIDTH-1].
    - SRL fills zeros at the MSB.
    - ROL wraps MSBs into the LSBs.
  - When the stage with idx=0 completes, go to DONE.
  - ctrl_shift is ignored in SHIFT; it is neither queued nor restarting.
- State DONE:
  - busy=0, data_resultRDY=1, data_result=acc.
  - data_result and data_resultRDY hold indefinitely.
  - ctrl_shift=1 at an edge is an accept, with the same load as in IDLE. Next state SHIFT and RDY drops on that edge.
- Latency:
  - Fixed at SHAMT_W (5) cycles from the accept edge to the edge that raises data_resultRDY, independent of shamt (including shamt=0).
  - Back-to-back throughput is one op per 6 cycles: a new op can be accepted in the first DONE cycle.
- data_result is registered. It equals acc only in DONE; in IDLE/SHIFT it holds its previous value (0 after reset), and the bench must not check it there.
- Input operands may change freely after the accept edge without affecting the result.
- Arithmetic: shamt is unsigned and ranges 0..WIDTH-1. SRA by 31 yields all copies of the sign bit. No overflow/flag outputs.

Test Plan:
- SRA then SLL:
  - Reset, then ctrl_shift with A=0x80000000, shamt=8, op=01 -> busy=1 for 5 cycles; data_resultRDY=1 on the 5th edge after accept with data_result=0xFF800000.
  - Then A=0x000000FF, shamt=8, op=00 -> 0x0000FF00.
- SRL and ROL: A=0x80000000, shamt=31, op=10 -> 0x00000001. A=0x80000001, shamt=4, op=11 -> 0x00000018. Each takes exactly 5 cycles.
- shamt=0: A=0xDEADBEEF, op=01 -> 0xDEADBEEF after the full 5-cycle latency. RDY holds with a stable result for 10 idle cycles afterwards.
- Busy ignore: during SHIFT pulse ctrl_shift with A=0x1, shamt=1 -> ignored, and the original op's result (A=0x12345678, shamt=4, SLL -> 0x23456780) is produced on schedule. A start in the first DONE cycle is accepted (RDY falls next edge).
- Reset mid-operation: assert reset=0 for one edge two cycles after accept -> busy=0, data_resultRDY=0, data_result=0 next cycle. No RDY ever appears for the aborted op. A fresh op afterwards completes correctly.
- Random sweep of ≥1000 random A/shamt/op triples compared against a golden model, with RDY asserted exactly 5 cycles after each accept.
